// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register: one-cycle latch between ex and mem. It
// handles stall (hold or bubble), flush, HI/LO and load/store fields,
// and returns multi-cycle arithmetic state to ex while ex is stalled.
module ex_mem_pipe #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ALUOP_W = 8,
    parameter int CNT_W   = 2,
    parameter int STALL_W = 6,
    parameter int EX_IDX  = 3,
    parameter int MEM_IDX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  flush,
    input  logic                  ex_wreg,
    input  logic [ADDR_W-1:0]     ex_wd,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic                  ex_whilo,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic [ALUOP_W-1:0]    ex_aluop,
    input  logic [DATA_W-1:0]     ex_mem_addr,
    input  logic [DATA_W-1:0]     ex_reg2,
    input  logic [2*DATA_W-1:0]   ex_hilo_temp,
    input  logic [CNT_W-1:0]      ex_cnt,
    output logic                  mem_valid,
    output logic                  mem_wreg,
    output logic [ADDR_W-1:0]     mem_wd,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_whilo,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic [ALUOP_W-1:0]    mem_aluop,
    output logic [DATA_W-1:0]     mem_mem_addr,
    output logic [DATA_W-1:0]     mem_reg2,
    output logic [2*DATA_W-1:0]   hilo_temp_o,
    output logic [CNT_W-1:0]      cnt_o
);

    logic ex_stall;
    logic mem_stall;

    assign ex_stall  = stall[EX_IDX];
    assign mem_stall = stall[MEM_IDX];

    // Pipeline register: reset/flush clear, bubble inserts a NOP while
    // returning multi-cycle state, advance loads from ex; any case with
    // mem stalled holds every register.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            mem_valid    <= 1'b0;
            mem_wreg     <= 1'b0;
            mem_wd       <= '0;
            mem_wdata    <= '0;
            mem_whilo    <= 1'b0;
            mem_hi       <= '0;
            mem_lo       <= '0;
            mem_aluop    <= '0;
            mem_mem_addr <= '0;
            mem_reg2     <= '0;
            hilo_temp_o  <= '0;
            cnt_o        <= '0;
        end else if (ex_stall && !mem_stall) begin
            mem_valid    <= 1'b0;
            mem_wreg     <= 1'b0;
            mem_wd       <= '0;
            mem_wdata    <= '0;
            mem_whilo    <= 1'b0;
            mem_hi       <= '0;
            mem_lo       <= '0;
            mem_aluop    <= '0;
            mem_mem_addr <= '0;
            mem_reg2     <= '0;
            hilo_temp_o  <= ex_hilo_temp;
            cnt_o        <= ex_cnt;
        end else if (!ex_stall && !mem_stall) begin
            mem_valid    <= 1'b1;
            mem_wreg     <= ex_wreg;
            mem_wd       <= ex_wd;
            mem_wdata    <= ex_wdata;
            mem_whilo    <= ex_whilo;
            mem_hi       <= ex_hi;
            mem_lo       <= ex_lo;
            mem_aluop    <= ex_aluop;
            mem_mem_addr <= ex_mem_addr;
            mem_reg2     <= ex_reg2;
            hilo_temp_o  <= '0;
            cnt_o        <= '0;
        end
    end

    // A younger stage must never advance into a stalled mem stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(!ex_stall && mem_stall))
                else $error("ex advancing into stalled mem");
        end
    end

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- Parametrised EX/MEM pipeline register for the five-stage core. Second generation of the plain EX/MEM latch.
- Adds stall-vector handling (hold vs. bubble insertion) and pipeline flush.
- Carries HI/LO write-back, load/store fields (aluop, memory address, store data) and a valid bit.
- Loops multi-cycle arithmetic state (hilo_temp, cnt) back to EX while EX is stalled. Sits between ex and mem.

Parameters:
- DATA_W, 32, width of register/HI/LO/address/store data.
- ADDR_W, 5, register-file address width.
- ALUOP_W, 8, ALU operation code width.
- CNT_W, 2, multi-cycle step counter width.
- STALL_W, 6, width of pipeline stall vector.
- EX_IDX, 3, stall-vector bit index of EX stage.
- MEM_IDX, 4, stall-vector bit index of MEM stage.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- stall  in  STALL_W  per-stage stall request, bit i=1 stalls stage i
- flush  in  1  squash in-flight instruction (exception)
- ex_wreg  in  1  GPR write enable
- ex_wd  in  ADDR_W  GPR destination
- ex_wdata  in  DATA_W  GPR write data
- ex_whilo  in  1  HI/LO write enable
- ex_hi, ex_lo  in  DATA_W each  HI/LO write data
- ex_aluop  in  ALUOP_W  operation code for mem
- ex_mem_addr  in  DATA_W  load/store address
- ex_reg2  in  DATA_W  store data
- ex_hilo_temp  in  2*DATA_W  multi-cycle partial result
- ex_cnt  in  CNT_W  multi-cycle step number
- mem_valid  out  1  registered instruction is real
- mem_wreg, mem_wd, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop, mem_mem_addr, mem_reg2  out  (widths as inputs)  registered copies
- hilo_temp_o  out  2*DATA_W  partial result returned to ex
- cnt_o  out  CNT_W  step number returned to ex

Behaviour:
- Latency: one cycle, EX input to mem_* output. All outputs registered; no combinational path input->output.
- Reset: rst is synchronous and active-high, sampled only on rising clk. While rst=1 at an edge, every output register clears to 0 (mem_valid=0, mem_wreg=0, mem_whilo=0, mem_wd=0, all data 0, hilo_temp_o=0, cnt_o=0).
- Per-edge priority when rst=0:
  1. flush=1: clear all outputs exactly as reset, including hilo_temp_o/cnt_o.
  2. stall[EX_IDX]=1 and stall[MEM_IDX]=0 (bubble):
     - mem_* fields clear to 0 and mem_valid=0; a NOP goes to mem.
     - hilo_temp_o<=ex_hilo_temp, cnt_o<=ex_cnt, so EX resumes its multi-cycle operation next cycle.
  3. stall[EX_IDX]=1 and stall[MEM_IDX]=1 (hold): every register keeps its value, including hilo_temp_o/cnt_o.
  4. stall[EX_IDX]=0 and stall[MEM_IDX]=1: illegal (younger stage cannot advance into a stalled one). Block holds all registers. The verification assertion flags it.
  5. stall[EX_IDX]=0 (advance):
     - All mem_* fields load from ex_*, and mem_valid=1.
     - hilo_temp_o<=0 and cnt_o<=0; the multi-cycle op is complete.
- Stall bits other than EX_IDX/MEM_IDX are ignored.
- flush and stall asserted together: flush wins.
- Reset asserted mid-stall or mid-multi-cycle: reset wins; partial state is discarded.
- No width conversion; every field passes unmodified.

Test Plan:
- Reset then advance:
  - Stimulus: rst=1 for 2 cycles, then stall=0, ex_wreg=1, ex_wd=5, ex_wdata=0x12345678.
  - Response: outputs all 0 during reset; one edge later mem_valid=1, mem_wd=5, mem_wdata=0x12345678, cnt_o=0.
- Bubble with multi-cycle state:
  - Stimulus: stall=6'b001111, ex_cnt=1, ex_hilo_temp=0x0000_0001_0000_0002, ex_wreg=1.
  - Response: mem_valid=0, mem_wreg=0, cnt_o=1, hilo_temp_o=0x0000_0001_0000_0002. Next cycle with stall=0: cnt_o=0, mem_valid=1.
- Hold:
  - Stimulus: load ex_wdata=0xAAAA_5555, then stall=6'b011111 for 3 cycles while ex_wdata=0xDEAD_BEEF.
  - Response: mem_wdata stays 0xAAAA_5555 for all 3 cycles.
- Flush priority:
  - Stimulus: valid instruction latched; next edge flush=1 with stall=6'b011111.
  - Response: all outputs 0, mem_valid=0, cnt_o=0.
- Store/HI-LO fields:
  - Stimulus: ex_whilo=1, ex_hi=0xFFFF_FFFF, ex_lo=0x1, ex_aluop=0x2B, ex_mem_addr=0x8000_0010, ex_reg2=0xCAFE_F00D, advance.
  - Response: each mem_* equals its input one cycle later.
- Reset during stall:
  - Stimulus: hold state, then rst=1 with stall=6'b011111.
  - Response: all outputs 0 after that edge.
